// File: rtl/snn_cls_pkg.sv
// Shared header for the spike-count classifier: FSM state encodings and the
// constant clog2 helper used to size counters and indices.
package snn_cls_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_ARGMAX = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/snn_spike_count_classifier_if.sv
// Handshake between the classifier (master) and the SNN core (slave): timestep
// start/index going out, done strobe and output spikes coming back.
interface snn_spike_count_classifier_if #(
  parameter int N_CLS = 5,
  parameter int CNT_W = 5
);
  logic             net_start;
  logic [CNT_W-1:0] step_idx;
  logic             net_done;
  logic [N_CLS-1:0] net_spikes;

  modport master (
    output net_start,
    output step_idx,
    input  net_done,
    input  net_spikes
  );

  modport slave (
    input  net_start,
    input  step_idx,
    output net_done,
    output net_spikes
  );
endinterface

// File: rtl/snn_argmax_scan.sv
// Sequential argmax: one strict-greater compare per cycle over a flattened value bus.
// done is high during the final compare; best_idx is final from the following cycle.
module snn_argmax_scan #(
  parameter int N_VALS = 5,
  parameter int VAL_W  = 4,
  parameter int IDX_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N_VALS*VAL_W-1:0] vals,
  output logic                    done,
  output logic [IDX_W-1:0]        best_idx
);

  logic             active_q, active_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [VAL_W-1:0] best_q, best_d;
  logic [VAL_W-1:0] cur_val;

  always_comb begin
    cur_val = '0;
    for (int k = 0; k < N_VALS; k++) begin
      if (idx_q == IDX_W'(k)) cur_val = vals[k*VAL_W +: VAL_W];
    end

    active_d   = active_q;
    idx_d      = idx_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    done       = 1'b0;

    if (start) begin
      active_d   = 1'b1;
      idx_d      = '0;
      best_d     = '0;
      best_idx_d = '0;
    end else if (active_q) begin
      // Strict compare keeps the lowest index on ties.
      if (cur_val > best_q) begin
        best_d     = cur_val;
        best_idx_d = idx_q;
      end
      if (idx_q == IDX_W'(N_VALS - 1)) begin
        active_d = 1'b0;
        done     = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
    end else begin
      active_q   <= active_d;
      idx_q      <= idx_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
    end
  end

  assign best_idx = best_idx_q;

endmodule

// File: rtl/snn_spike_count_classifier.sv
// Spike-count classifier head: runs N_STEPS core timesteps, accumulates output spikes
// per class, then reports the argmax. Optional watchdog: define SNN_CLS_TIMEOUT_EN.
module snn_spike_count_classifier
  import snn_cls_pkg::*;
#(
  parameter int  N_CLS       = 5,
  parameter int  N_STEPS     = 16,
  parameter int  TIMEOUT_CYC = 64,
  localparam int CNT_W       = clog2(N_STEPS + 1),
  localparam int CLS_W       = (N_CLS > 1) ? clog2(N_CLS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     infer_start,
  output logic                     busy,
  snn_spike_count_classifier_if.master core,
  output logic                     result_valid,
  output logic [CLS_W-1:0]         class_id,
  output logic [N_CLS*CNT_W-1:0]   counts,
  output logic                     timeout_err
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_STEPS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(N_STEPS);

  if (N_STEPS < 1 || N_CLS < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("snn_spike_count_classifier: N_STEPS, N_CLS and TIMEOUT_CYC must be >= 1");
  end

  logic [2:0]                  state_q, state_d;
  logic [CNT_W-1:0]            step_idx_q, step_idx_d;
  logic [N_CLS-1:0][CNT_W-1:0] counts_q, counts_d;
  logic                        net_start_q, net_start_d;
  logic                        busy_q, busy_d;
  logic                        result_valid_q, result_valid_d;
  logic                        scan_start, scan_done;
  logic [CLS_W-1:0]            best_idx;

`ifdef SNN_CLS_TIMEOUT_EN
  localparam int WDOG_W = clog2(TIMEOUT_CYC + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout_err_q, timeout_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    step_idx_d = step_idx_q;
    counts_d   = counts_q;
    scan_start = 1'b0;
`ifdef SNN_CLS_TIMEOUT_EN
    wdog_d        = wdog_q;
    timeout_err_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (infer_start) begin
          state_d    = ST_ISSUE;
          step_idx_d = '0;
          counts_d   = '0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef SNN_CLS_TIMEOUT_EN
        wdog_d = '0;
`endif
      end
      ST_WAIT: begin
        if (core.net_done) begin
          for (int k = 0; k < N_CLS; k++) begin
            if (core.net_spikes[k] && counts_q[k] != MAX_CNT)
              counts_d[k] = counts_q[k] + CNT_W'(1);
          end
          // The scan starts now so its compares land on the fully updated counts.
          if (step_idx_q == LAST_STEP) begin
            state_d    = ST_ARGMAX;
            scan_start = 1'b1;
          end else begin
            step_idx_d = step_idx_q + CNT_W'(1);
            state_d    = ST_ISSUE;
          end
        end
`ifdef SNN_CLS_TIMEOUT_EN
        else if (wdog_q == WDOG_W'(TIMEOUT_CYC - 1)) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
`endif
      end
      ST_ARGMAX: begin
        if (scan_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    net_start_d    = (state_d == ST_ISSUE);
    busy_d         = (state_d != ST_IDLE);
    result_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      step_idx_q     <= '0;
      counts_q       <= '0;
      net_start_q    <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_idx_q     <= step_idx_d;
      counts_q       <= counts_d;
      net_start_q    <= net_start_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
    end
  end

`ifdef SNN_CLS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  snn_argmax_scan #(
    .N_VALS (N_CLS),
    .VAL_W  (CNT_W),
    .IDX_W  (CLS_W)
  ) u_argmax (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (scan_start),
    .vals     (counts_q),
    .done     (scan_done),
    .best_idx (best_idx)
  );

  assign busy          = busy_q;
  assign core.net_start = net_start_q;
  assign core.step_idx  = step_idx_q;
  assign result_valid  = result_valid_q;
  assign class_id      = best_idx;
  assign counts        = counts_q;

endmodule

// File: tb/tb_snn_spike_count_classifier.sv
// Directed bench for snn_spike_count_classifier (N_STEPS=4, N_CLS=5, TIMEOUT_CYC=8);
// the timeout scenario follows SNN_CLS_TIMEOUT_EN when it is defined.
module tb_snn_spike_count_classifier;

  localparam int N_CLS       = 5;
  localparam int N_STEPS     = 4;
  localparam int TIMEOUT_CYC = 8;
  localparam int CNT_W       = 3;
  localparam int CLS_W       = 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   infer_start;
  logic                   busy;
  logic                   result_valid;
  logic [CLS_W-1:0]       class_id;
  logic [N_CLS*CNT_W-1:0] counts;
  logic                   timeout_err;

  int checks = 0;
  int errors = 0;
  int ns_cnt = 0;
  int rv_cnt = 0;
  int to_cnt = 0;

  snn_spike_count_classifier_if #(.N_CLS(N_CLS), .CNT_W(CNT_W)) core_if ();

  snn_spike_count_classifier #(
    .N_CLS       (N_CLS),
    .N_STEPS     (N_STEPS),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .infer_start  (infer_start),
    .busy         (busy),
    .core         (core_if.master),
    .result_valid (result_valid),
    .class_id     (class_id),
    .counts       (counts),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (core_if.net_start) ns_cnt <= ns_cnt + 1;
    if (result_valid)      rv_cnt <= rv_cnt + 1;
    if (timeout_err)       to_cnt <= to_cnt + 1;
  end

  task automatic apply_reset();
    rst_n              = 1'b0;
    infer_start        = 1'b0;
    core_if.net_done   = 1'b0;
    core_if.net_spikes = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Core model: answers each net_start after lat cycles with that step's spikes.
  task automatic run_inference(input logic [N_STEPS*N_CLS-1:0] spikes, input int lat,
                               input bit hold_start, input int spurious_step,
                               output bit ok, output int rv_lat,
                               output logic [N_STEPS*CNT_W-1:0] steps_seen);
    int n;
    ok         = 1'b1;
    rv_lat     = 0;
    steps_seen = '0;
    infer_start = 1'b1;
    @(posedge clk); #1;
    infer_start = hold_start;
    for (int s = 0; s < N_STEPS; s++) begin
      n = 0;
      while (!core_if.net_start && n < 30) begin
        @(posedge clk); #1;
        n++;
      end
      if (!core_if.net_start) begin
        ok = 1'b0;
        return;
      end
      steps_seen[s*CNT_W +: CNT_W] = core_if.step_idx;
      if (s == spurious_step) begin
        core_if.net_done   = 1'b1;
        core_if.net_spikes = '1;
      end
      repeat (lat) begin
        @(posedge clk); #1;
        core_if.net_done   = 1'b0;
        core_if.net_spikes = '0;
      end
      core_if.net_done   = 1'b1;
      core_if.net_spikes = spikes[s*N_CLS +: N_CLS];
      @(posedge clk); #1;
      core_if.net_done   = 1'b0;
      core_if.net_spikes = '0;
    end
    n = 1;
    while (!result_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!result_valid) ok = 1'b0;
    else rv_lat = n;
  endtask

  task automatic test_reset();
    rst_n              = 1'b0;
    infer_start        = 1'b0;
    core_if.net_done   = 1'b0;
    core_if.net_spikes = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (core_if.net_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_net_start: got %0b expected 0", core_if.net_start); end
    checks++; if (core_if.step_idx !== 3'd0) begin errors++; $display("[TB] FAIL reset_step_idx: got %0d expected 0", core_if.step_idx); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_result_valid: got %0b expected 0", result_valid); end
    checks++; if (class_id !== 3'd0) begin errors++; $display("[TB] FAIL reset_class_id: got %0d expected 0", class_id); end
    checks++; if (counts !== 15'd0) begin errors++; $display("[TB] FAIL reset_counts: got %h expected 0", counts); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout_err: got %0b expected 0", timeout_err); end
  endtask

  task automatic test_single_class();
    bit ok; int lat; logic [N_STEPS*CNT_W-1:0] steps; int ns0; int rv0;
    apply_reset();
    ns0 = ns_cnt; rv0 = rv_cnt;
    run_inference({N_STEPS{5'b00100}}, 2, 1'b0, -1, ok, lat, steps);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL single_complete: got %0b expected 1", ok); end
    checks++; if (steps !== 12'h688) begin errors++; $display("[TB] FAIL single_step_idx: got %h expected 688", steps); end
    checks++; if (lat !== 6) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 6", lat); end
    checks++; if (class_id !== 3'd2) begin errors++; $display("[TB] FAIL single_class_id: got %0d expected 2", class_id); end
    checks++; if (counts !== {3'd0, 3'd0, 3'd4, 3'd0, 3'd0}) begin errors++; $display("[TB] FAIL single_counts: got %h expected %h", counts, {3'd0, 3'd0, 3'd4, 3'd0, 3'd0}); end
    @(posedge clk); #1;
    checks++; if (ns_cnt - ns0 !== 4) begin errors++; $display("[TB] FAIL single_net_start_pulses: got %0d expected 4", ns_cnt - ns0); end
    checks++; if (rv_cnt - rv0 !== 1) begin errors++; $display("[TB] FAIL single_result_pulses: got %0d expected 1", rv_cnt - rv0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_tie_and_zero();
    bit ok; int lat; logic [N_STEPS*CNT_W-1:0] steps;
    apply_reset();
    run_inference({5'b00011, 5'b00001, 5'b00010, 5'b00011}, 1, 1'b0, -1, ok, lat, steps);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL tie_complete: got %0b expected 1", ok); end
    checks++; if (counts !== {3'd0, 3'd0, 3'd0, 3'd3, 3'd3}) begin errors++; $display("[TB] FAIL tie_counts: got %h expected %h", counts, {3'd0, 3'd0, 3'd0, 3'd3, 3'd3}); end
    checks++; if (class_id !== 3'd0) begin errors++; $display("[TB] FAIL tie_class_id: got %0d expected 0", class_id); end
    @(posedge clk); #1;
    run_inference({5'b00001, 5'b10010, 5'b10000, 5'b10001}, 3, 1'b0, -1, ok, lat, steps);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL top4_complete: got %0b expected 1", ok); end
    checks++; if (counts !== {3'd3, 3'd0, 3'd0, 3'd1, 3'd2}) begin errors++; $display("[TB] FAIL top4_counts: got %h expected %h", counts, {3'd3, 3'd0, 3'd0, 3'd1, 3'd2}); end
    checks++; if (class_id !== 3'd4) begin errors++; $display("[TB] FAIL top4_class_id: got %0d expected 4", class_id); end
    @(posedge clk); #1;
    run_inference('0, 1, 1'b0, -1, ok, lat, steps);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL zero_complete: got %0b expected 1", ok); end
    checks++; if (counts !== 15'd0) begin errors++; $display("[TB] FAIL zero_counts: got %h expected 0", counts); end
    checks++; if (class_id !== 3'd0) begin errors++; $display("[TB] FAIL zero_class_id: got %0d expected 0", class_id); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    bit ok; int lat; logic [N_STEPS*CNT_W-1:0] steps; int ns0;
    apply_reset();
    for (int l = 1; l <= 7; l += 6) begin
      ns0 = ns_cnt;
      run_inference({N_STEPS{5'b01000}}, l, 1'b0, -1, ok, lat, steps);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL lat%0d_complete: got %0b expected 1", l, ok); end
      checks++; if (lat !== N_CLS + 1) begin errors++; $display("[TB] FAIL lat%0d_result_delay: got %0d expected %0d", l, lat, N_CLS + 1); end
      checks++; if (ns_cnt - ns0 !== 4) begin errors++; $display("[TB] FAIL lat%0d_net_start_pulses: got %0d expected 4", l, ns_cnt - ns0); end
      checks++; if (class_id !== 3'd3) begin errors++; $display("[TB] FAIL lat%0d_class_id: got %0d expected 3", l, class_id); end
      checks++; if (counts !== {3'd0, 3'd4, 3'd0, 3'd0, 3'd0}) begin errors++; $display("[TB] FAIL lat%0d_counts: got %h expected %h", l, counts, {3'd0, 3'd4, 3'd0, 3'd0, 3'd0}); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int lat; logic [N_STEPS*CNT_W-1:0] steps; int ns0; int rv0;
    apply_reset();
    ns0 = ns_cnt; rv0 = rv_cnt;
    run_inference({N_STEPS{5'b00100}}, 2, 1'b1, 1, ok, lat, steps);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL hold_complete: got %0b expected 1", ok); end
    checks++; if (steps !== 12'h688) begin errors++; $display("[TB] FAIL hold_step_idx: got %h expected 688", steps); end
    checks++; if (counts !== {3'd0, 3'd0, 3'd4, 3'd0, 3'd0}) begin errors++; $display("[TB] FAIL hold_counts: got %h expected %h", counts, {3'd0, 3'd0, 3'd4, 3'd0, 3'd0}); end
    checks++; if (class_id !== 3'd2) begin errors++; $display("[TB] FAIL hold_class_id: got %0d expected 2", class_id); end
    checks++; if (ns_cnt - ns0 !== 4) begin errors++; $display("[TB] FAIL hold_net_start_pulses: got %0d expected 4", ns_cnt - ns0); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL hold_idle_busy: got %0b expected 0", busy); end
    checks++; if (rv_cnt - rv0 !== 1) begin errors++; $display("[TB] FAIL hold_result_pulses: got %0d expected 1", rv_cnt - rv0); end
    @(posedge clk); #1;
    checks++; if (core_if.net_start !== 1'b1) begin errors++; $display("[TB] FAIL hold_restart_net_start: got %0b expected 1", core_if.net_start); end
    checks++; if (core_if.step_idx !== 3'd0) begin errors++; $display("[TB] FAIL hold_restart_step_idx: got %0d expected 0", core_if.step_idx); end
    checks++; if (counts !== 15'd0) begin errors++; $display("[TB] FAIL hold_restart_counts: got %h expected 0", counts); end
    infer_start = 1'b0;
    apply_reset();
  endtask

  task automatic test_reset_mid_run();
    bit ok; int lat; logic [N_STEPS*CNT_W-1:0] steps; int rv0; int n;
    apply_reset();
    rv0 = rv_cnt;
    infer_start = 1'b1;
    @(posedge clk); #1;
    infer_start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      n = 0;
      while (!core_if.net_start && n < 30) begin @(posedge clk); #1; n++; end
      checks++; if (core_if.net_start !== 1'b1) begin errors++; $display("[TB] FAIL midrst_step%0d_issue: got %0b expected 1", s, core_if.net_start); end
      if (s < 2) begin
        @(posedge clk); #1;
        core_if.net_done   = 1'b1;
        core_if.net_spikes = 5'b11111;
        @(posedge clk); #1;
        core_if.net_done   = 1'b0;
        core_if.net_spikes = '0;
      end
    end
    checks++; if (core_if.step_idx !== 3'd2) begin errors++; $display("[TB] FAIL midrst_step_idx: got %0d expected 2", core_if.step_idx); end
    checks++; if (counts !== {3'd2, 3'd2, 3'd2, 3'd2, 3'd2}) begin errors++; $display("[TB] FAIL midrst_partial_counts: got %h expected %h", counts, {3'd2, 3'd2, 3'd2, 3'd2, 3'd2}); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %0b expected 0", busy); end
    checks++; if (core_if.net_start !== 1'b0) begin errors++; $display("[TB] FAIL midrst_net_start: got %0b expected 0", core_if.net_start); end
    checks++; if (core_if.step_idx !== 3'd0) begin errors++; $display("[TB] FAIL midrst_step_idx_cleared: got %0d expected 0", core_if.step_idx); end
    checks++; if (counts !== 15'd0) begin errors++; $display("[TB] FAIL midrst_counts: got %h expected 0", counts); end
    repeat (12) @(posedge clk);
    #1;
    checks++; if (rv_cnt - rv0 !== 0) begin errors++; $display("[TB] FAIL midrst_no_result: got %0d pulses expected 0", rv_cnt - rv0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_stays_idle: got %0b expected 0", busy); end
    run_inference({N_STEPS{5'b10000}}, 2, 1'b0, -1, ok, lat, steps);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL midrst_rerun_complete: got %0b expected 1", ok); end
    checks++; if (steps !== 12'h688) begin errors++; $display("[TB] FAIL midrst_rerun_steps: got %h expected 688", steps); end
    checks++; if (counts !== {3'd4, 3'd0, 3'd0, 3'd0, 3'd0}) begin errors++; $display("[TB] FAIL midrst_rerun_counts: got %h expected %h", counts, {3'd4, 3'd0, 3'd0, 3'd0, 3'd0}); end
    checks++; if (class_id !== 3'd4) begin errors++; $display("[TB] FAIL midrst_rerun_class_id: got %0d expected 4", class_id); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int rv0; int to0; int n;
    apply_reset();
    rv0 = rv_cnt; to0 = to_cnt;
    infer_start = 1'b1;
    @(posedge clk); #1;
    infer_start = 1'b0;
    n = 0;
    while (!core_if.net_start && n < 30) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    core_if.net_done   = 1'b1;
    core_if.net_spikes = 5'b00100;
    @(posedge clk); #1;
    core_if.net_done   = 1'b0;
    core_if.net_spikes = '0;
    checks++; if (core_if.step_idx !== 3'd1) begin errors++; $display("[TB] FAIL timeout_step1: got %0d expected 1", core_if.step_idx); end
`ifdef SNN_CLS_TIMEOUT_EN
    n = 0;
    while (!timeout_err && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_pulse: got %0b expected 1", timeout_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_busy: got %0b expected 0", busy); end
    checks++; if (counts !== {3'd0, 3'd0, 3'd1, 3'd0, 3'd0}) begin errors++; $display("[TB] FAIL timeout_partial_counts: got %h expected %h", counts, {3'd0, 3'd0, 3'd1, 3'd0, 3'd0}); end
    @(posedge clk); #1;
    checks++; if (to_cnt - to0 !== 1) begin errors++; $display("[TB] FAIL timeout_pulse_count: got %0d expected 1", to_cnt - to0); end
    checks++; if (rv_cnt - rv0 !== 0) begin errors++; $display("[TB] FAIL timeout_no_result: got %0d expected 0", rv_cnt - rv0); end
`else
    repeat (40) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL nowdog_busy: got %0b expected 1", busy); end
    checks++; if (to_cnt - to0 !== 0) begin errors++; $display("[TB] FAIL nowdog_timeout_pulses: got %0d expected 0", to_cnt - to0); end
    checks++; if (rv_cnt - rv0 !== 0) begin errors++; $display("[TB] FAIL nowdog_no_result: got %0d expected 0", rv_cnt - rv0); end
    apply_reset();
`endif
  endtask

  initial begin
    test_reset();
    test_single_class();
    test_tie_and_zero();
    test_latency();
    test_back_to_back();
    test_reset_mid_run();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
